// File: rtl/serial_wb_pkg.sv
// Shared definitions for the serial Wishbone burst master.
// Contents: command op-byte bit indices, status-byte bit indices and the
// command FSM state type. No ports.
package serial_wb_pkg;
    localparam int OP_WE  = 0;   // op bit: write
    localparam int OP_INC = 1;   // op bit: auto-increment address per beat
    localparam int OP_SEL = 2;   // op bit: a sel byte follows the address

    localparam int ST_ERR = 0;   // status bit: at least one beat ended in err
    localparam int ST_TO  = 1;   // status bit: burst aborted by ack timeout
    localparam int ST_WE  = 2;   // status bit: command was a write

    typedef enum logic [2:0] {
        S_GET_OP,
        S_GET_ADDR,
        S_GET_SEL,
        S_GET_COUNT,
        S_BUS_ACTIVE,
        S_DRAIN,
        S_PAD,
        S_STATUS
    } state_t;
endpackage

// File: rtl/wb_outstanding_tracker.sv
// Counts Wishbone beats issued but not yet terminated, flags when that count
// reaches the limit, and raises a timeout when beats are outstanding and no
// ack/err has been seen for TIMEOUT_CYCLES consecutive cycles.
// Ports:
//   clk, sresetn  clock, synchronous active-low reset
//   beat          a beat is accepted this cycle (stb && !stall)
//   done          a beat terminates this cycle (ack | err, while cyc)
//   outstanding   current issued-but-unterminated beat count
//   at_limit      outstanding == MAX_OUTSTANDING
//   timeout       combinational; the cycle the timeout expires. Outstanding
//                 beats are discarded on the following edge.
module wb_outstanding_tracker #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1),
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          sresetn,
    input  logic          beat,
    input  logic          done,
    output logic [OW-1:0] outstanding,
    output logic          at_limit,
    output logic          timeout
);
    logic [OW-1:0] out_reg, out_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          done_ok;
    logic          idle;

    // A stray ack with nothing outstanding must not wrap the counter.
    assign done_ok = done && (out_reg != '0);
    assign idle    = (out_reg != '0) && !done;
    assign timeout = idle && (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        out_next = out_reg;
        case ({beat, done_ok})
            2'b10:   out_next = out_reg + OW'(1);
            2'b01:   out_next = out_reg - OW'(1);
            default: out_next = out_reg;
        endcase
        to_cnt_next = idle ? to_cnt_reg + TW'(1) : '0;
        if (timeout) begin
            out_next    = '0;
            to_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            out_reg    <= '0;
            to_cnt_reg <= '0;
        end else begin
            out_reg    <= out_next;
            to_cnt_reg <= to_cnt_next;
        end
    end

    assign outstanding = out_reg;
    assign at_limit    = (out_reg == OW'(MAX_OUTSTANDING));
endmodule

// File: rtl/serial_wb_master_burst.sv
// Byte-stream to pipelined Wishbone burst bridge. Parses op/addr/[sel]/count
// commands from an 8-bit stream, issues N beats with an outstanding limit and
// ack timeout, and returns read data (MSB first) followed by a status byte
// carrying tlast.
// Ports:
//   clk, sresetn              clock, synchronous active-low reset
//   axis_i_*                  command byte stream (ready/valid/data)
//   axis_o_*                  response byte stream (ready/valid/last/data)
//   m_wb_*                    pipelined Wishbone master
module serial_wb_master_burst
    import serial_wb_pkg::*;
#(
    parameter int BYTES           = 4,
    parameter int ADDR_BITS       = 32,
    parameter int COUNT_BYTES     = 2,
    parameter int MAX_OUTSTANDING = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                 clk,
    input  logic                 sresetn,
    output logic                 axis_i_tready,
    input  logic                 axis_i_tvalid,
    input  logic [7:0]           axis_i_tdata,
    input  logic                 axis_o_tready,
    output logic                 axis_o_tvalid,
    output logic                 axis_o_tlast,
    output logic [7:0]           axis_o_tdata,
    output logic [ADDR_BITS-1:0] m_wb_addr,
    output logic [BYTES*8-1:0]   m_wb_dat_m2s,
    input  logic [BYTES*8-1:0]   m_wb_dat_s2m,
    output logic                 m_wb_we,
    output logic [BYTES-1:0]     m_wb_sel,
    output logic                 m_wb_stb,
    output logic                 m_wb_cyc,
    input  logic                 m_wb_ack,
    input  logic                 m_wb_err,
    input  logic                 m_wb_stall
);
    localparam int W          = BYTES * 8;
    localparam int ADDR_BYTES = (ADDR_BITS + 7) / 8;
    localparam int CW         = COUNT_BYTES * 8;
    localparam int DEPTH      = 2 * MAX_OUTSTANDING;
    localparam int PW         = $clog2(DEPTH);
    localparam int FW         = $clog2(DEPTH + 1);
    localparam int OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW         = $clog2(BYTES + 1);

    state_t               state_reg, state_next;
    logic [2:0]           op_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [BYTES-1:0]     sel_reg;
    logic [CW-1:0]        count_reg, issued_reg, ret_reg, count_shift;
    logic [3:0]           field_reg;
    logic [W-1:0]         wdata_reg;
    logic [BW-1:0]        wcnt_reg;
    logic                 wfull_reg;
    logic                 err_flag_reg, to_flag_reg;
    logic [W-1:0]         mem [DEPTH];
    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [FW-1:0]        fifo_cnt_reg;
    logic [W-1:0]         ob_reg;
    logic [BW-1:0]        ob_left_reg;

    logic          in_hs, out_hs, bus_st, beat, done, timeout, at_limit;
    logic          credit_ok, push, pad_push, pop, data_valid, status_valid;
    logic [OW-1:0] outstanding;
    logic [W-1:0]  rd_word, push_data;
    logic [7:0]    status_byte;

    wb_outstanding_tracker #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tracker (
        .clk        (clk),
        .sresetn    (sresetn),
        .beat       (beat),
        .done       (done),
        .outstanding(outstanding),
        .at_limit   (at_limit),
        .timeout    (timeout)
    );

    // A read beat terminated by err returns an all-zero word.
    genvar gi;
    for (gi = 0; gi < BYTES; gi++) begin : g_rd_lane
        assign rd_word[gi*8 +: 8] = m_wb_err ? 8'h00 : m_wb_dat_s2m[gi*8 +: 8];
    end

    assign count_shift = CW'({count_reg, axis_i_tdata});
    assign in_hs       = axis_i_tvalid && axis_i_tready;
    assign bus_st      = (state_reg == S_BUS_ACTIVE) || (state_reg == S_DRAIN);
    assign done        = m_wb_cyc && (m_wb_ack || m_wb_err);
    // Reads only issue when the response FIFO can hold every beat in flight,
    // so returning data never needs to be stalled.
    assign credit_ok   = (int'(fifo_cnt_reg) + int'(outstanding)) < DEPTH;
    assign beat        = m_wb_stb && !m_wb_stall;
    assign pad_push    = (state_reg == S_PAD) && !op_reg[OP_WE] &&
                         (ret_reg != count_reg) && (fifo_cnt_reg != FW'(DEPTH));
    assign push        = (done && !op_reg[OP_WE]) || pad_push;
    assign push_data   = pad_push ? '0 : rd_word;
    assign pop         = (ob_left_reg == '0) && (fifo_cnt_reg != '0);

    assign data_valid   = (ob_left_reg != '0);
    assign status_valid = (state_reg == S_STATUS) && (fifo_cnt_reg == '0) && !data_valid;
    assign status_byte  = {5'b0, op_reg[OP_WE], to_flag_reg, err_flag_reg};
    assign out_hs       = axis_o_tvalid && axis_o_tready;

    assign axis_o_tvalid = data_valid || status_valid;
    assign axis_o_tlast  = !data_valid && status_valid;
    assign axis_o_tdata  = data_valid ? ob_reg[W-1 -: 8] : status_byte;
    assign m_wb_addr     = addr_reg;
    assign m_wb_dat_m2s  = wdata_reg;
    assign m_wb_we       = op_reg[OP_WE];
    assign m_wb_sel      = sel_reg;

    always_comb begin
        state_next    = state_reg;
        axis_i_tready = 1'b0;
        m_wb_cyc      = bus_st && !timeout;
        m_wb_stb      = (state_reg == S_BUS_ACTIVE) && !timeout && (issued_reg < count_reg) &&
                        !at_limit && (op_reg[OP_WE] ? wfull_reg : credit_ok);
        case (state_reg)
            S_GET_OP: begin
                axis_i_tready = 1'b1;
                if (in_hs) state_next = S_GET_ADDR;
            end
            S_GET_ADDR: begin
                axis_i_tready = 1'b1;
                if (in_hs && field_reg == 4'(ADDR_BYTES - 1))
                    state_next = op_reg[OP_SEL] ? S_GET_SEL : S_GET_COUNT;
            end
            S_GET_SEL: begin
                axis_i_tready = 1'b1;
                if (in_hs) state_next = S_GET_COUNT;
            end
            S_GET_COUNT: begin
                axis_i_tready = 1'b1;
                if (in_hs && field_reg == 4'(COUNT_BYTES - 1))
                    state_next = (count_shift == '0) ? S_STATUS : S_BUS_ACTIVE;
            end
            S_BUS_ACTIVE: begin
                axis_i_tready = op_reg[OP_WE] && !wfull_reg;
                if (timeout)
                    state_next = S_PAD;
                else if (beat && issued_reg == count_reg - CW'(1))
                    state_next = S_DRAIN;
            end
            S_DRAIN:  if (timeout || outstanding == '0) state_next = S_PAD;
            S_PAD:    if (op_reg[OP_WE] || ret_reg == count_reg) state_next = S_STATUS;
            S_STATUS: if (out_hs && !data_valid) state_next = S_GET_OP;
            default:  state_next = S_GET_OP;
        endcase
        // Held in reset: nothing may be accepted from the stream.
        if (!sresetn) axis_i_tready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state_reg    <= S_GET_OP;
            op_reg       <= '0;
            addr_reg     <= '0;
            sel_reg      <= '1;
            count_reg    <= '0;
            issued_reg   <= '0;
            ret_reg      <= '0;
            field_reg    <= '0;
            wcnt_reg     <= '0;
            wfull_reg    <= 1'b0;
            err_flag_reg <= 1'b0;
            to_flag_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
            ob_left_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (in_hs) begin
                field_reg <= (state_next != state_reg) ? 4'd0 : field_reg + 4'd1;
                case (state_reg)
                    S_GET_OP: begin
                        op_reg     <= axis_i_tdata[2:0];
                        sel_reg    <= '1;
                        issued_reg <= '0;
                        ret_reg    <= '0;
                        wcnt_reg   <= '0;
                        wfull_reg  <= 1'b0;
                    end
                    S_GET_ADDR:  addr_reg  <= ADDR_BITS'({addr_reg, axis_i_tdata});
                    S_GET_SEL:   sel_reg   <= axis_i_tdata[BYTES-1:0];
                    S_GET_COUNT: count_reg <= count_shift;
                    S_BUS_ACTIVE: begin
                        wdata_reg <= W'({wdata_reg, axis_i_tdata});
                        wcnt_reg  <= wcnt_reg + BW'(1);
                        if (wcnt_reg == BW'(BYTES - 1)) wfull_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (beat) begin
                issued_reg <= issued_reg + CW'(1);
                wfull_reg  <= 1'b0;
                wcnt_reg   <= '0;
                if (op_reg[OP_INC]) addr_reg <= addr_reg + ADDR_BITS'(1);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
                ret_reg    <= ret_reg + CW'(1);
            end
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + PW'(1);
                ob_left_reg <= BW'(BYTES);
            end else if (out_hs && data_valid) begin
                ob_left_reg <= ob_left_reg - BW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + FW'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - FW'(1);
                default: ;
            endcase
            if (m_wb_cyc && m_wb_err) err_flag_reg <= 1'b1;
            if (timeout)              to_flag_reg  <= 1'b1;
            if (state_reg == S_STATUS && out_hs && !data_valid) begin
                err_flag_reg <= 1'b0;
                to_flag_reg  <= 1'b0;
            end
        end
    end

    // Response storage and byte narrowing: kept free of reset so the array
    // maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_data;
        if (pop)
            ob_reg <= mem[rd_ptr_reg];
        else if (out_hs && data_valid)
            ob_reg <= ob_reg << 8;
    end
endmodule

// File: tb/tb_serial_wb_master_burst.sv
module tb_serial_wb_master_burst;
    localparam int MAXO = 16;

    logic        clk = 1'b0;
    logic        sresetn = 1'b0;
    logic        axis_i_tready, axis_i_tvalid;
    logic [7:0]  axis_i_tdata;
    logic        axis_o_tready, axis_o_tvalid, axis_o_tlast;
    logic [7:0]  axis_o_tdata;
    logic [31:0] m_wb_addr, m_wb_dat_m2s, m_wb_dat_s2m;
    logic        m_wb_we, m_wb_stb, m_wb_cyc, m_wb_ack, m_wb_err, m_wb_stall;
    logic [3:0]  m_wb_sel;

    always #5 clk = ~clk;

    serial_wb_master_burst dut (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid), .axis_i_tdata(axis_i_tdata),
        .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid),
        .axis_o_tlast(axis_o_tlast), .axis_o_tdata(axis_o_tdata),
        .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_dat_s2m(m_wb_dat_s2m),
        .m_wb_we(m_wb_we), .m_wb_sel(m_wb_sel), .m_wb_stb(m_wb_stb), .m_wb_cyc(m_wb_cyc),
        .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err), .m_wb_stall(m_wb_stall)
    );

    typedef struct { logic [7:0] data; logic last; } rsp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] sel; } beat_t;
    typedef struct { logic [31:0] addr; logic we; logic err; int due; } pend_t;

    rsp_t        exp_rsp[$];
    beat_t       exp_beat[$];
    pend_t       pend[$];
    logic [31:0] wdq[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    int n_checks = 0, n_pass = 0, rsp_idx = 0;
    int lat = 1, stall_pct = 0, err_idx = -1, slave_beat = 0, cycle = 0;
    int outst = 0, peak = 0, cyc_cycles = 0;
    bit never_ack = 0, bp_on = 0, gap_on = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] sel_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int k = 0; k < 4; k++) if (s[k]) m[k*8 +: 8] = 8'hFF;
        return m;
    endfunction

    // Wishbone slave: random stall, fixed ack latency, optional err / no ack.
    // Also checks every accepted beat against the expected beat queue.
    initial begin
        pend_t p;
        beat_t e;
        logic [31:0] old, m;
        m_wb_ack = 0; m_wb_err = 0; m_wb_stall = 0; m_wb_dat_s2m = '0;
        forever begin
            @(negedge clk);
            if (!m_wb_cyc) begin
                pend.delete();
                outst = 0;
            end else begin
                cyc_cycles++;
                if (m_wb_ack || m_wb_err) outst--;
                if (m_wb_stb && !m_wb_stall) begin
                    p.addr = m_wb_addr; p.we = m_wb_we;
                    p.err = (slave_beat == err_idx); p.due = cycle + lat;
                    if (p.we && !p.err) begin
                        old = slave_mem.exists(p.addr) ? slave_mem[p.addr] : init_word(p.addr);
                        m = sel_mask(m_wb_sel);
                        slave_mem[p.addr] = (old & ~m) | (m_wb_dat_m2s & m);
                    end
                    pend.push_back(p);
                    outst++;
                    if (outst > peak) peak = outst;
                    if (exp_beat.size() == 0) begin
                        check($sformatf("beat%0d_unexpected", slave_beat), 1, 0);
                    end else begin
                        e = exp_beat.pop_front();
                        check($sformatf("beat%0d_addr", slave_beat), m_wb_addr, e.addr);
                        check($sformatf("beat%0d_we", slave_beat), m_wb_we, e.we);
                        if (e.we) begin
                            check($sformatf("beat%0d_wdata", slave_beat), m_wb_dat_m2s, e.data);
                            check($sformatf("beat%0d_sel", slave_beat), m_wb_sel, e.sel);
                        end
                    end
                    slave_beat++;
                end
            end
            @(posedge clk); #1;
            cycle++;
            m_wb_ack = 0; m_wb_err = 0; m_wb_dat_s2m = '0;
            if (pend.size() > 0 && pend[0].due <= cycle && !never_ack) begin
                p = pend.pop_front();
                if (p.err) m_wb_err = 1;
                else begin
                    m_wb_ack = 1;
                    if (!p.we)
                        m_wb_dat_s2m = slave_mem.exists(p.addr) ? slave_mem[p.addr] : init_word(p.addr);
                end
            end
            m_wb_stall = ($urandom_range(99) < stall_pct);
        end
    end

    // Response monitor: pops the scoreboard on every handshake.
    initial begin
        rsp_t r;
        axis_o_tready = 0;
        forever begin
            @(negedge clk);
            if (axis_o_tvalid && axis_o_tready) begin
                if (exp_rsp.size() == 0) begin
                    check($sformatf("rsp_unexpected_0x%02h", axis_o_tdata), 1, 0);
                end else begin
                    r = exp_rsp.pop_front();
                    check($sformatf("rsp%0d_data", rsp_idx), axis_o_tdata, r.data);
                    check($sformatf("rsp%0d_last", rsp_idx), axis_o_tlast, r.last);
                end
                rsp_idx++;
            end
            @(posedge clk); #1;
            axis_o_tready = bp_on ? ($urandom_range(3) != 0) : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit hs = 0;
        int guard = 0;
        if (gap_on && $urandom_range(3) == 0) begin @(posedge clk); #1; end
        axis_i_tvalid = 1; axis_i_tdata = b;
        while (!hs && guard < 3000) begin
            @(negedge clk); hs = axis_i_tready;
            @(posedge clk); #1; guard++;
        end
        axis_i_tvalid = 0;
        if (!hs) check("send_byte_accepted", 0, 1);
    endtask

    // Reference model: builds expected beats and response bytes from the
    // command fields, then drives the command and waits for the status byte.
    task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [7:0] selb, input int n);
        logic        we = op[0], inc = op[1], sp = op[2];
        logic [3:0]  sel = sp ? selb[3:0] : 4'hF;
        logic [31:0] a = addr, word, m;
        logic        errd = 0;
        logic [7:0]  st;
        rsp_t        r;
        beat_t       b;
        int          guard = 0;
        slave_beat = 0; peak = 0; cyc_cycles = 0;
        for (int i = 0; i < n; i++) begin
            b.we = we; b.addr = a; b.sel = sel; b.data = we ? wdq[i] : '0;
            exp_beat.push_back(b);
            word = '0;
            if (never_ack) word = '0;
            else if (i == err_idx) errd = 1;
            else if (we) begin
                m = sel_mask(sel);
                word = model_mem.exists(a) ? model_mem[a] : init_word(a);
                model_mem[a] = (word & ~m) | (wdq[i] & m);
            end else word = model_mem.exists(a) ? model_mem[a] : init_word(a);
            if (!we) for (int k = 3; k >= 0; k--) begin
                r.data = word[k*8 +: 8]; r.last = 0; exp_rsp.push_back(r);
            end
            if (inc) a = a + 1;
        end
        st = {5'b0, we, never_ack && (n > 0), errd};
        r.data = st; r.last = 1; exp_rsp.push_back(r);
        send_byte(op);
        for (int k = 3; k >= 0; k--) send_byte(addr[k*8 +: 8]);
        if (sp) send_byte(selb);
        send_byte(n[15:8]); send_byte(n[7:0]);
        if (we) for (int i = 0; i < n; i++)
            for (int k = 3; k >= 0; k--) send_byte(wdq[i][k*8 +: 8]);
        while (exp_rsp.size() != 0 && guard < 6000) begin @(posedge clk); #1; guard++; end
        check("rsp_complete", exp_rsp.size(), 0);
        check("beats_complete", exp_beat.size(), 0);
        check("peak_within_limit", peak <= MAXO, 1);
        exp_rsp.delete(); exp_beat.delete();
        $display("cmd op=%02h addr=%08h n=%0d exp_status=%02h peak=%0d cyc_cycles=%0d",
                 op, addr, n, st, peak, cyc_cycles);
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        beat_t b;
        int guard;
        logic [7:0] op, selb;
        int n;
        axis_i_tvalid = 0; axis_i_tdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", m_wb_cyc, 0);
        check("rst_stb", m_wb_stb, 0);
        check("rst_we", m_wb_we, 0);
        check("rst_sel", m_wb_sel, 4'hF);
        check("rst_addr", m_wb_addr, 0);
        check("rst_tvalid", axis_o_tvalid, 0);
        check("rst_tlast", axis_o_tlast, 0);
        check("rst_tready", axis_i_tready, 0);
        @(posedge clk); #1; sresetn = 1;
        repeat (2) @(posedge clk); #1;

        lat = 1; wdq = '{32'h11223344, 32'h55667788};
        run_cmd(8'h03, 32'h10, 8'h00, 2);
        lat = 2;
        run_cmd(8'h02, 32'h10, 8'h00, 3);
        lat = 1; wdq = '{32'hA1B2C3D4};
        run_cmd(8'h05, 32'h20, 8'h03, 1);
        run_cmd(8'h00, 32'h20, 8'h00, 1);
        lat = 20;
        run_cmd(8'h02, 32'h100, 8'h00, 40);
        check("limit_peak", peak, MAXO);
        lat = 1; never_ack = 1;
        run_cmd(8'h02, 32'h40, 8'h00, 2);
        check("timeout_cyc_cycles", cyc_cycles, 1024);
        never_ack = 0; err_idx = 1;
        run_cmd(8'h02, 32'h50, 8'h00, 2);
        err_idx = -1;
        run_cmd(8'h02, 32'h60, 8'h00, 0);
        check("count0_no_cyc", cyc_cycles, 0);
        run_cmd(8'h01, 32'h60, 8'h00, 0);
        check("count0w_no_cyc", cyc_cycles, 0);

        // Reset in the middle of a burst: bus drops, nothing is emitted.
        lat = 20; slave_beat = 0;
        for (int i = 0; i < 40; i++) begin
            b.we = 0; b.addr = 32'h200 + i; b.sel = 4'hF; b.data = '0;
            exp_beat.push_back(b);
        end
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'd40);
        guard = 0;
        while (slave_beat < 5 && guard < 200) begin @(posedge clk); #1; guard++; end
        check("rst_burst_started", slave_beat >= 5, 1);
        sresetn = 0;
        @(negedge clk);
        check("midrst_tready", axis_i_tready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_cyc", m_wb_cyc, 0);
        check("midrst_stb", m_wb_stb, 0);
        check("midrst_tvalid", axis_o_tvalid, 0);
        @(posedge clk); #1; sresetn = 1;
        exp_beat.delete();
        repeat (40) @(posedge clk); #1;
        $display("cmd reset_mid_burst beats_before_reset=%0d", slave_beat);

        // Randomised commands with backpressure, stalls and occasional err.
        bp_on = 1; gap_on = 1;
        for (int t = 0; t < 14; t++) begin
            op = 8'($urandom_range(7)) | 8'($urandom_range(31) << 3);
            selb = 8'($urandom_range(255));
            n = $urandom_range(6);
            lat = $urandom_range(1, 4);
            stall_pct = $urandom_range(50);
            err_idx = (n > 0 && $urandom_range(3) == 0) ? $urandom_range(n - 1) : -1;
            wdq.delete();
            for (int i = 0; i < n; i++) wdq.push_back($urandom);
            run_cmd(op, 32'($urandom_range(24)), selb, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
